lfsr_checker: RTL
=================

# lfsr_checker

Receive-side companion to the 24-bit noise LFSR. Consumes the signed 16-bit samples the generator emits, one generator step per valid sample. Reconstructs the full 24-bit generator state, then flywheels a local copy to predict every following sample, declares lock, and counts mismatches. Used in the noise/velocity path to prove a tap is intact after routing and delay, and as a bench self-check.

## Interface
- CONFIRM_N, 16: consecutive correct predictions required in VERIFY before lock.
- LOSS_N, 4: consecutive mispredictions in LOCKED that drop lock.
- CNT_W, 16: width of the error counter.

- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; all state cleared while low.
- sample_in  in  16  signed generator sample; equals generator state bits [23:8].
- sample_valid  in  1  sample_in carries the next generator step; low = hold everything.
- clear_cnt  in  1  synchronous clear of err_count.
- locked  out  1  registered lock flag.
- err_pulse  out  1  one-cycle strobe per mispredicted sample while LOCKED.
- err_count  out  CNT_W  saturating count of mispredictions while LOCKED.
- state_est  out  24  local generator state estimate (last predicted state).

## Operation
- Generator step: fb = s[23]^s[22]^s[20]^s[19]; next(s) = {s[22:0], fb}. If the result is 24'h000000 it is replaced by ~24'h9FFFAF = 24'h600050 (zero rescue, same as generator).
- Reset values: locked=0, err_pulse=0, err_count=0, state_est=0, FSM=HUNT, hunt index=0, all run counters 0.
- All activity qualified by sample_valid; with it low, FSM, counters and state_est hold, err_pulse=0.
- HUNT (index k=0..8):
  - k=0: hist[23:8] <= sample_in; k <= 1.
  - k=1..8: if sample_in[15:1] != previous sample[14:0], restart: this sample becomes new s0, k <= 1. Else hist[8-k] <= sample_in[0]; k <= k+1.
  - After the k=8 sample is accepted, hist = state at s0. Load state_est = hist advanced 8 steps (unrolled, zero rescue applied each step); go VERIFY, match run = 0.
- VERIFY: per valid sample P = next(state_est); compare sample_in vs P[23:8]. Match: state_est <= P, run+1; at run = CONFIRM_N go LOCKED. Mismatch: go HUNT with this sample as new s0 (k <= 1). err_count not touched.
- LOCKED: P = next(state_est); state_est <= P regardless (flywheel). Match: miss run = 0. Mismatch: err_pulse=1, err_count+1 saturating at all-ones, miss run+1; at miss run = LOSS_N go HUNT (k=0), locked <= 0.
- clear_cnt: err_count <= 0 next edge; coincident with a counted error, clear wins (result 0), err_pulse still fires.
- Arithmetic: compare is bitwise on 16 bits; signedness of sample_in is irrelevant inside the block.

## Timing
- All outputs registered; no combinational path from inputs to outputs.
- err_pulse asserts on the edge that consumes the bad sample, lasts one cycle.
- locked rises on the edge consuming the CONFIRM_N-th matching VERIFY sample; from a clean stream, 9 + CONFIRM_N valid samples after reset release.
- locked falls on the edge consuming the LOSS_N-th consecutive bad sample.
- Reset low mid-operation: outputs go to reset values immediately (asynchronous), acquisition restarts from k=0 after release.
- Back-to-back valid every cycle sustained; gaps of any length allowed anywhere without affecting result.

## Test plan
- Reset: hold reset low, toggle inputs -> locked=0, err_count=0, err_pulse=0, state_est=0.
- Clean lock: feed generator stream from seed 24'h9FFFAF (s0=16'h9FFF, s1=16'h3FFF, ...) every cycle -> locked high after exactly 25 valid samples (defaults), err_count stays 0 for 1000 samples.
- Single hit: while locked, flip bit 3 of one sample -> one err_pulse, err_count=1, locked stays 1, next samples match.
- Loss and relock: corrupt 4 consecutive samples -> err_count=4, locked=0 after 4th; resume clean stream -> relock after 25 further valid samples.
- Gaps and HUNT restart: random sample_valid duty 30% during HUNT, plus one sample breaking the shift-consistency check at k=5 -> acquisition restarts from that sample, lock still reached, no err_pulse.
- Counter edges: force err_count to 16'hFFFF then inject error -> stays 16'hFFFF; clear_cnt coincident with an error -> err_count=0, err_pulse=1; async reset asserted while locked -> locked=0 same cycle.

Source files
------------

// File: rtl/lfsr_checker.sv
// lfsr_checker: acquires the 24-bit noise LFSR state from its 16-bit samples, flywheels a local copy,
// tracks lock and counts mispredicted samples.
module lfsr_checker #(
  parameter int CONFIRM_N = 16,
  parameter int LOSS_N    = 4,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      sample_in,
  input  logic             sample_valid,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_count,
  output logic [23:0]      state_est
);
  localparam int RW = $clog2(CONFIRM_N + 1);
  localparam int MW = $clog2(LOSS_N + 1);
  typedef enum logic [1:0] {HUNT, VERIFY, LOCK} st_t;
  st_t st;
  logic [3:0]  k;
  logic [23:0] hist;
  logic [15:0] prev;
  logic [RW-1:0] run;
  logic [MW-1:0] miss;
  logic [23:0] pred, adv;
  logic hit, shift_ok;
  function automatic logic [23:0] step(input logic [23:0] s);
    logic [23:0] n;
    n = {s[22:0], s[23] ^ s[22] ^ s[20] ^ s[19]};
    return (n == 24'h0) ? 24'h600050 : n;
  endfunction
  always_comb begin
    pred     = step(state_est);
    hit      = sample_in == pred[23:8];
    shift_ok = sample_in[15:1] == prev[14:0];
    adv      = {hist[23:8], hist[6:0], sample_in[0]};
    for (int i = 0; i < 8; i++) adv = step(adv);
  end
  // hist[7:0] fills as a shift register: the bit from the first follow-on sample lands in bit 7.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st        <= HUNT;
      k         <= '0;
      hist      <= '0;
      prev      <= '0;
      run       <= '0;
      miss      <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_count <= '0;
      state_est <= '0;
    end else begin
      err_pulse <= 1'b0;
      if (clear_cnt) err_count <= '0;
      if (sample_valid) begin
        case (st)
          HUNT: begin
            prev <= sample_in;
            if (k == 4'd0 || !shift_ok) begin
              hist[23:8] <= sample_in;
              k          <= 4'd1;
            end else if (k == 4'd8) begin
              state_est <= adv;
              st        <= VERIFY;
              run       <= '0;
              k         <= '0;
            end else begin
              hist[7:0] <= {hist[6:0], sample_in[0]};
              k         <= k + 4'd1;
            end
          end
          VERIFY: begin
            if (hit) begin
              state_est <= pred;
              run       <= run + 1'b1;
              if (run == RW'(CONFIRM_N - 1)) begin
                st     <= LOCK;
                locked <= 1'b1;
                miss   <= '0;
              end
            end else begin
              st         <= HUNT;
              hist[23:8] <= sample_in;
              prev       <= sample_in;
              k          <= 4'd1;
            end
          end
          LOCK: begin
            state_est <= pred;
            if (hit) miss <= '0;
            else begin
              err_pulse <= 1'b1;
              if (!clear_cnt) err_count <= &err_count ? err_count : err_count + 1'b1;
              miss <= miss + 1'b1;
              if (miss == MW'(LOSS_N - 1)) begin
                st     <= HUNT;
                k      <= '0;
                locked <= 1'b0;
                miss   <= '0;
              end
            end
          end
          default: st <= HUNT;
        endcase
      end
    end
  end
endmodule
